// File: rtl/mnist_frame_packer.sv
// mnist_frame_packer
// Accepts an MNIST image as LANES 8-bit pixels per beat, quantizes each pixel
// to 2 bits and packs the frame into the flat vector feeding the pipeline M0.
// The last complete frame is held on frame_o; frame_valid_o strobes on update.
// Optional feature macro: PACKER_LAST_CHECK_EN enables s_last framing checks
// (early/late last detection, sticky err_o and a DROP state).
module mnist_frame_packer #(
    parameter int NUM_PIXELS = 784,
    parameter int PIX_W      = 8,
    parameter int Q_W        = 2,
    parameter int LANES      = 4,
    parameter int T1         = 64,
    parameter int T2         = 128,
    parameter int T3         = 192
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [LANES*PIX_W-1:0]      s_data,
    input  logic                        s_last,
    output logic [NUM_PIXELS*Q_W-1:0]   frame_o,
    output logic                        frame_valid_o,
    output logic [15:0]                 frame_cnt_o,
    output logic                        err_o
);

    localparam int BEATS   = NUM_PIXELS / LANES;
    localparam int BEAT_W  = LANES * Q_W;
    localparam int FRAME_W = NUM_PIXELS * Q_W;
    localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

`ifdef PACKER_LAST_CHECK_EN
    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_DROP = 1'b1;
    logic [0:0]             state_r;
    logic [0:0]             state_nxt_s;
`else
    // s_last carries no meaning when frames are delimited by the counter only
    logic                   unused_last_s;
    assign unused_last_s = s_last;
`endif

    logic                   s_ready_r;
    logic [FRAME_W-1:0]     frame_r;
    logic [FRAME_W-1:0]     shadow_r;
    logic                   frame_valid_r;
    logic [15:0]            frame_cnt_r;
    logic                   err_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic [BEAT_W-1:0]      q_beat_s;
    logic                   accept_s;
    logic                   wr_s;
    logic                   commit_s;
    logic                   err_set_s;

    // Unsigned 2-bit threshold quantizer: 3 if p>=T3, 2 if p>=T2, 1 if p>=T1
    function automatic logic [1:0] quant(input logic [PIX_W-1:0] p);
        logic [31:0] pw;
        logic [1:0]  q;
        pw = 32'(p);
        if (pw >= 32'(T3)) begin
            q = 2'd3;
        end else if (pw >= 32'(T2)) begin
            q = 2'd2;
        end else if (pw >= 32'(T1)) begin
            q = 2'd1;
        end else begin
            q = 2'd0;
        end
        return q;
    endfunction

    assign accept_s = s_valid && s_ready_r;

    // Quantize every lane of the incoming beat
    always_comb begin
        q_beat_s = '0;
        for (int j = 0; j < LANES; j++) begin
            q_beat_s[j*Q_W +: Q_W] = quant(s_data[j*PIX_W +: PIX_W]);
        end
    end

    // Beat sequencing: decide between shadow write, commit and framing error
    always_comb begin
        cnt_nxt_s = cnt_r;
        wr_s      = 1'b0;
        commit_s  = 1'b0;
        err_set_s = 1'b0;
`ifdef PACKER_LAST_CHECK_EN
        state_nxt_s = state_r;
        if (accept_s) begin
            case (state_r)
                ST_DROP: begin
                    // discard until the sender closes the broken frame
                    if (s_last) begin
                        state_nxt_s = ST_FILL;
                        cnt_nxt_s   = '0;
                    end else begin
                        cnt_nxt_s   = '0;
                    end
                end
                ST_FILL: begin
                    if (cnt_r == CNT_LAST) begin
                        if (s_last) begin
                            commit_s  = 1'b1;
                            cnt_nxt_s = '0;
                        end else begin
                            err_set_s   = 1'b1;
                            state_nxt_s = ST_DROP;
                            cnt_nxt_s   = '0;
                        end
                    end else if (s_last) begin
                        // early last: drop the partial frame, resync at beat 0
                        err_set_s = 1'b1;
                        cnt_nxt_s = '0;
                    end else begin
                        wr_s      = 1'b1;
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt_s = ST_FILL;
                    cnt_nxt_s   = '0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
`else
        if (accept_s) begin
            if (cnt_r == CNT_LAST) begin
                commit_s  = 1'b1;
                cnt_nxt_s = '0;
            end else begin
                wr_s      = 1'b1;
                cnt_nxt_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
`endif
    end

    // State, shadow buffer and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_ready_r     <= 1'b0;
            frame_r       <= '0;
            shadow_r      <= '0;
            frame_valid_r <= 1'b0;
            frame_cnt_r   <= 16'd0;
            err_r         <= 1'b0;
            cnt_r         <= '0;
`ifdef PACKER_LAST_CHECK_EN
            state_r       <= ST_FILL;
`endif
        end else begin
            s_ready_r     <= 1'b1;
            cnt_r         <= cnt_nxt_s;
            frame_valid_r <= commit_s;
            if (wr_s) begin
                shadow_r[int'(cnt_r)*BEAT_W +: BEAT_W] <= q_beat_s;
            end
            if (commit_s) begin
                // the final beat bypasses the shadow and lands in the top slot
                frame_r     <= {q_beat_s, shadow_r[FRAME_W-BEAT_W-1:0]};
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end
`ifdef PACKER_LAST_CHECK_EN
            state_r <= state_nxt_s;
`endif
        end
    end

    assign s_ready       = s_ready_r;
    assign frame_o       = frame_r;
    assign frame_valid_o = frame_valid_r;
    assign frame_cnt_o   = frame_cnt_r;
    assign err_o         = err_r;

endmodule

// File: doc/mnist_frame_packer.md
# mnist_frame_packer

Input stage that sits directly upstream of the `polylut_add` pipeline. It accepts an MNIST image as a stream of 8-bit grayscale pixels, `LANES` pixels per beat, over a valid/ready handshake. Each pixel is quantized to 2 bits, and the pixels are packed into the flat `NUM_PIXELS*Q_W`-bit vector that drives the pipeline's `M0` input. The last valid frame is held stable on the output, and a one-cycle strobe marks each new frame.

## Interface
- `NUM_PIXELS`, default 784: pixels per frame. Must be a multiple of `LANES`.
- `PIX_W`, default 8: width of each input pixel.
- `Q_W`, default 2: quantized width per pixel. Fixed at 2; the quantizer is 2-bit only.
- `LANES`, default 4: pixels per beat. BEATS = NUM_PIXELS/LANES (196 at defaults).
- `T1`, `T2`, `T3`, defaults 64, 128, 192: quantization thresholds. Requires T1<T2<T3.
- `clk  in  1`: rising-edge clock.
- `rst  in  1`: asynchronous, active-low reset.
- `s_valid  in  1`: input beat valid.
- `s_ready  out  1`: packer can accept a beat.
- `s_data  in  LANES*PIX_W`: pixels. Lane j occupies bits [j*PIX_W +: PIX_W].
- `s_last  in  1`: marks the final beat of a frame.
- `frame_o  out  NUM_PIXELS*Q_W`: packed frame. Connects to the pipeline's `M0`.
- `frame_valid_o  out  1`: one-cycle strobe when `frame_o` updates.
- `frame_cnt_o  out  16`: count of frames committed; wraps modulo 2^16.
- `err_o  out  1`: sticky framing-error flag.

## Operation
- A beat is accepted when `s_valid && s_ready`.
- Pixel mapping: beat k, lane j carries pixel i = k*LANES+j. Its quantized value goes to `frame_o[2i+1:2i]`.
- Quantizer: q = 3 if p≥T3; 2 if p≥T2; 1 if p≥T1; else 0. Comparisons are unsigned.
- Beat counter `cnt` runs 0..BEATS-1. Quantized beats are written into a shadow buffer.
- State FILL, normal case:
  - Accepted beat with cnt<BEATS-1: write the shadow buffer, cnt+1.
  - Accepted beat with cnt==BEATS-1: load `frame_o` with the shadow contents plus this beat, pulse `frame_valid_o`, increment `frame_cnt_o`, set cnt=0.
- State DROP: exists only when `PACKER_LAST_CHECK_EN` is defined; framing errors and the FILL↔DROP transitions are given under Configuration.
- `s_ready` is 1 in every state once out of reset. The packer never back-pressures, because the pipeline consumes `frame_o` every cycle.
- `frame_o` holds its value between commits. A partial frame never reaches `frame_o`.

## Timing
- Reset values: `s_ready`=0, `frame_o`=0, `frame_valid_o`=0, `frame_cnt_o`=0, `err_o`=0, cnt=0, state FILL.
- `s_ready` rises on the first rising edge after `rst` deasserts.
- Latency: `frame_o` and `frame_valid_o` update on the edge that accepts the final beat, so they are visible in the next cycle. `frame_valid_o` is high for exactly one cycle.
- Back-to-back frames: beat 0 of frame n+1 may be accepted in the cycle right after the final beat of frame n. Sustained throughput is one frame per BEATS cycles.
- A beat with `s_valid` low is a bubble: no state change.
- Reset mid-frame discards the partial frame and clears `frame_o`.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `PACKER_LAST_CHECK_EN` defined enables `s_last` checking:
  - Early last: an accepted beat with `s_last`=1 and cnt<BEATS-1. Discard the partial frame, set `err_o`, cnt=0, stay in FILL, no commit.
  - Late last: an accepted beat with cnt==BEATS-1 and `s_last`=0. No commit, set `err_o`, enter DROP.
  - In DROP, discard accepted beats until one with `s_last`=1, then return to FILL with cnt=0.
  - `err_o` clears only on reset.
- Not defined: `s_last` is ignored, the DROP state is absent, `err_o` is tied to 0, and frames are delimited by the counter alone.

## Test plan
- Reset, then 196 beats of all pixels =200 with `s_last` on beat 195 → the cycle after beat 195: `frame_o`=all ones (1568 bits), `frame_valid_o` high for 1 cycle, `frame_cnt_o`=1.
- Beat 0 `s_data`={8'd192, 8'd128, 8'd64, 8'd63} (lanes 3..0), all other pixels 0 → `frame_o[7:0]`=8'b11_10_01_00, the rest zero.
- Two frames back-to-back with random `s_valid` gaps → two strobes, each exactly 196 accepted beats after the previous commit. Bubbles do not change `frame_o`.
- `PACKER_LAST_CHECK_EN` defined: `s_last` on beat 100 → no strobe, `err_o`=1. The next 196-beat frame commits normally with `frame_cnt_o`=1.
- `PACKER_LAST_CHECK_EN` defined: 196 beats with no `s_last`, then 5 more beats with `s_last` on the 5th → no strobe, `err_o`=1. A following clean frame commits.
- Assert `rst` low at beat 50 → all outputs return to reset values immediately. The next full frame commits with `frame_cnt_o`=1.
